// File: rtl/fetch_stage_bpred.sv
// ---------------------------------------------------------------------------
// fetch_stage_bpred
//   Instruction fetch stage with a gshare direction predictor (PHT of 2-bit
//   saturating counters indexed by PC ^ GHR) and a direct-mapped BTB.
//   Owns the PC and drives the FE latch consumed by decode.
//
// Ports
//   clk, reset                      rising-edge clock, async active-high reset
//   imem_addr / imem_rdata          fetch address (= PC) and same-cycle data
//   stall_DE                        hold PC and FE latch
//   redirect_AGEX/redirect_pc_AGEX  mispredict flush and refetch address
//   bpu_*_AGEX                      resolved branch/jump training interface
//   fe_*                            FE latch towards decode
// ---------------------------------------------------------------------------
module fetch_stage_bpred #(
    parameter int                DBITS        = 32,
    parameter logic [DBITS-1:0]  STARTPC      = 32'h0000_0200,
    parameter int                GHR_BITS     = 8,
    parameter int                BTB_IDX_BITS = 4
) (
    input  logic                clk,
    input  logic                reset,
    output logic [DBITS-1:0]    imem_addr,
    input  logic [31:0]         imem_rdata,
    input  logic                stall_DE,
    input  logic                redirect_AGEX,
    input  logic [DBITS-1:0]    redirect_pc_AGEX,
    input  logic                bpu_valid_AGEX,
    input  logic [DBITS-1:0]    bpu_pc_AGEX,
    input  logic [GHR_BITS-1:0] bpu_pht_idx_AGEX,
    input  logic                bpu_taken_AGEX,
    input  logic [DBITS-1:0]    bpu_target_AGEX,
    input  logic                bpu_uncond_AGEX,
    output logic [31:0]         fe_inst,
    output logic [DBITS-1:0]    fe_pc,
    output logic [DBITS-1:0]    fe_pcplus,
    output logic [GHR_BITS-1:0] fe_pht_idx,
    output logic [DBITS-1:0]    fe_pred_pc,
    output logic [DBITS-1:0]    fe_inst_count,
    output logic                fe_invalid
);

    localparam int PHT_N = 1 << GHR_BITS;
    localparam int BTB_N = 1 << BTB_IDX_BITS;
    localparam int TAG_W = DBITS - BTB_IDX_BITS - 2;
    localparam logic [DBITS-1:0] INSN_BYTES = DBITS'(4);
    localparam logic [DBITS-1:0] ONE        = DBITS'(1);

    // 2-bit saturating counter step: up on taken, down on not-taken
    function automatic logic [1:0] sat_step(input logic [1:0] ctr, input logic up);
        logic [1:0] r;
        case ({up, ctr})
            3'b1_11: r = 2'b11;
            3'b0_00: r = 2'b00;
            3'b1_00, 3'b1_01, 3'b1_10: r = ctr + 2'b01;
            3'b0_01, 3'b0_10, 3'b0_11: r = ctr - 2'b01;
            default: r = ctr;
        endcase
        return r;
    endfunction

    // Architectural state
    logic [DBITS-1:0]    pc_q, pc_d;
    logic [DBITS-1:0]    cnt_q, cnt_d;
    logic [GHR_BITS-1:0] ghr_q, ghr_d;
    logic [1:0]          pht_q        [PHT_N];
    logic                btb_valid_q  [BTB_N];
    logic [TAG_W-1:0]    btb_tag_q    [BTB_N];
    logic [DBITS-1:0]    btb_target_q [BTB_N];
    logic                btb_uncond_q [BTB_N];

    // FE latch
    logic [31:0]         fe_inst_q,    fe_inst_d;
    logic [DBITS-1:0]    fe_pc_q,      fe_pc_d;
    logic [DBITS-1:0]    fe_pcplus_q,  fe_pcplus_d;
    logic [GHR_BITS-1:0] fe_idx_q,     fe_idx_d;
    logic [DBITS-1:0]    fe_pred_q,    fe_pred_d;
    logic [DBITS-1:0]    fe_cnt_q,     fe_cnt_d;
    logic                fe_invalid_q, fe_invalid_d;

    // Prediction / training combinational signals
    logic [GHR_BITS-1:0]     pht_idx_s;
    logic [BTB_IDX_BITS-1:0] btb_idx_s;
    logic                    btb_hit_s;
    logic [DBITS-1:0]        pcplus_s;
    logic [DBITS-1:0]        pred_pc_s;
    logic [1:0]              pht_wr_s;
    logic [BTB_IDX_BITS-1:0] btb_wr_idx_s;
    logic                    unused_s;

    assign imem_addr     = pc_q;
    assign fe_inst       = fe_inst_q;
    assign fe_pc         = fe_pc_q;
    assign fe_pcplus     = fe_pcplus_q;
    assign fe_pht_idx    = fe_idx_q;
    assign fe_pred_pc    = fe_pred_q;
    assign fe_inst_count = fe_cnt_q;
    assign fe_invalid    = fe_invalid_q;

    // Byte-offset bits of the training PC carry no information
    assign unused_s = ^bpu_pc_AGEX[1:0];

    // Prediction on the current PC, using pre-update table contents
    always_comb begin
        pht_idx_s = pc_q[GHR_BITS+1:2] ^ ghr_q;
        btb_idx_s = pc_q[BTB_IDX_BITS+1:2];
        btb_hit_s = btb_valid_q[btb_idx_s] &&
                    (btb_tag_q[btb_idx_s] == pc_q[DBITS-1:BTB_IDX_BITS+2]);
        pcplus_s  = pc_q + INSN_BYTES;
        if (btb_hit_s && (btb_uncond_q[btb_idx_s] || pht_q[pht_idx_s][1])) begin
            pred_pc_s = btb_target_q[btb_idx_s];
        end else begin
            pred_pc_s = pcplus_s;
        end
    end

    // Next PC / FE latch / count: redirect beats stall beats normal fetch
    always_comb begin
        pc_d         = pc_q;
        cnt_d        = cnt_q;
        fe_inst_d    = fe_inst_q;
        fe_pc_d      = fe_pc_q;
        fe_pcplus_d  = fe_pcplus_q;
        fe_idx_d     = fe_idx_q;
        fe_pred_d    = fe_pred_q;
        fe_cnt_d     = fe_cnt_q;
        fe_invalid_d = fe_invalid_q;
        if (redirect_AGEX) begin
            pc_d         = redirect_pc_AGEX;
            fe_inst_d    = 32'h0000_0000;
            fe_pc_d      = '0;
            fe_pcplus_d  = '0;
            fe_idx_d     = '0;
            fe_pred_d    = '0;
            fe_cnt_d     = '0;
            fe_invalid_d = 1'b1;
        end else if (stall_DE) begin
            pc_d  = pc_q;
            cnt_d = cnt_q;
        end else begin
            pc_d         = pred_pc_s;
            cnt_d        = cnt_q + ONE;
            fe_inst_d    = imem_rdata;
            fe_pc_d      = pc_q;
            fe_pcplus_d  = pcplus_s;
            fe_idx_d     = pht_idx_s;
            fe_pred_d    = pred_pc_s;
            fe_cnt_d     = cnt_q;
            fe_invalid_d = 1'b0;
        end
    end

    // Training values; GHR only moves on resolved conditional branches
    always_comb begin
        ghr_d        = ghr_q;
        pht_wr_s     = sat_step(pht_q[bpu_pht_idx_AGEX], bpu_taken_AGEX);
        btb_wr_idx_s = bpu_pc_AGEX[BTB_IDX_BITS+1:2];
        if (bpu_valid_AGEX && !bpu_uncond_AGEX) begin
            ghr_d = {ghr_q[GHR_BITS-2:0], bpu_taken_AGEX};
        end else begin
            ghr_d = ghr_q;
        end
    end

    // PC, count, GHR and FE latch registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q         <= STARTPC;
            cnt_q        <= '0;
            ghr_q        <= '0;
            fe_inst_q    <= 32'h0000_0000;
            fe_pc_q      <= '0;
            fe_pcplus_q  <= '0;
            fe_idx_q     <= '0;
            fe_pred_q    <= '0;
            fe_cnt_q     <= '0;
            fe_invalid_q <= 1'b1;
        end else begin
            pc_q         <= pc_d;
            cnt_q        <= cnt_d;
            ghr_q        <= ghr_d;
            fe_inst_q    <= fe_inst_d;
            fe_pc_q      <= fe_pc_d;
            fe_pcplus_q  <= fe_pcplus_d;
            fe_idx_q     <= fe_idx_d;
            fe_pred_q    <= fe_pred_d;
            fe_cnt_q     <= fe_cnt_d;
            fe_invalid_q <= fe_invalid_d;
        end
    end

    // PHT counters, reset to weakly not-taken
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < PHT_N; i++) begin
                pht_q[i] <= 2'b01;
            end
        end else if (bpu_valid_AGEX && !bpu_uncond_AGEX) begin
            pht_q[bpu_pht_idx_AGEX] <= pht_wr_s;
        end
    end

    // BTB valid bits: set on any taken resolution
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < BTB_N; i++) begin
                btb_valid_q[i] <= 1'b0;
            end
        end else if (bpu_valid_AGEX && bpu_taken_AGEX) begin
            btb_valid_q[btb_wr_idx_s] <= 1'b1;
        end
    end

    // BTB payload (tag/target/kind); only meaningful when valid
    always_ff @(posedge clk) begin
        if (bpu_valid_AGEX && bpu_taken_AGEX) begin
            btb_tag_q[btb_wr_idx_s]    <= bpu_pc_AGEX[DBITS-1:BTB_IDX_BITS+2];
            btb_target_q[btb_wr_idx_s] <= bpu_target_AGEX;
            btb_uncond_q[btb_wr_idx_s] <= bpu_uncond_AGEX;
        end
    end

endmodule
